// File: rtl/pulse_link_pkg.sv
// Shared definitions for the LabView pulse link.
// Holds the frame header default, frame length, flag bit positions,
// the readback frame FSM state encoding and the default UART bit period
// for a 12 MHz clock at 115200 baud.
package pulse_link_pkg;

  // 12 MHz / 115200 baud, rounded to the nearest whole cycle
  localparam int CLKS_PER_BIT_DEFAULT = 104;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         FRAME_BYTES    = 13;
  localparam logic [3:0] LAST_BYTE      = 4'(FRAME_BYTES - 1);

  // Bit positions inside the flags byte
  localparam int CP_BIT = 0;
  localparam int BL_BIT = 1;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_LOAD,
    FS_SHIFT,
    FS_NEXT,
    FS_FINISH
  } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
// Ports:
//   clk       - clock
//   reset     - synchronous active-high reset
//   start     - load data and begin a byte (taken only while ready is high)
//   data      - byte to send, LSB first
//   tx        - serial line, idle high
//   ready     - can take a byte this cycle (idle, or last stop-bit cycle)
//   byte_done - high in the last cycle of the stop bit
// A byte started in the byte_done cycle follows with no idle gap.
module uart_tx_byte
  import pulse_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       byte_done
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  logic              active_q, active_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;

    bit_end   = active_q && (baud_q == BAUD_LAST);
    byte_done = bit_end && (bit_q == STOP_BIT);
    ready     = !active_q || byte_done;

    if (active_q) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    // Bit boundary inside a byte: present the next bit. The shift register
    // carries the stop bit as its MSB, so the ninth shift yields a 1.
    if (bit_end && !byte_done) begin
      bit_d   = bit_q + 4'd1;
      tx_d    = shift_q[0];
      shift_d = {1'b1, shift_q[8:1]};
    end

    if (byte_done) begin
      active_d = 1'b0;
      tx_d     = 1'b1;
    end

    // A start in the byte_done cycle overrides the return to idle
    if (start && ready) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = {1'b1, data};
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx = tx_q;

endmodule

// File: rtl/param_readback_tx.sv
// Pulse parameter readback transmitter.
// On an accepted send, snapshots the live pulse parameters and sends a
// 13-byte frame over 8N1 UART:
//   HEADER, per[23:0] (3 bytes MSB first), p1wid, del, p2wid (2 bytes each,
//   MSB first), p_bl, flags {6'b0, bl, cp}, checksum (sum of bytes 1..11).
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   send                  - request; while busy, queued once (depth 1)
//   per, p1wid, del,
//   p2wid, p_bl, cp, bl   - live parameter set
//   tx                    - serial out, idle high
//   busy                  - frame in flight or queued
//   done                  - one-cycle pulse after the last stop bit
module param_readback_tx
  import pulse_link_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [23:0] per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [7:0]  p_bl,
  input  logic        cp,
  input  logic        bl,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  frame_state_e state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   csum_q, csum_d;
  logic         pend_q, pend_d;

  logic [23:0]  per_q;
  logic [15:0]  p1wid_q, del_q, p2wid_q;
  logic [7:0]   p_bl_q, flags_q, flags_live;

  logic         accept, start_req, uart_start, uart_ready, byte_done;
  logic [7:0]   tx_byte, nxt_byte;
  logic [3:0]   nxt_idx;

  always_comb begin
    flags_live         = '0;
    flags_live[CP_BIT] = cp;
    flags_live[BL_BIT] = bl;
  end

  // Byte mux over the snapshot; the checksum slot reads the running sum,
  // which already holds bytes 1..11 when byte 12 is selected.
  assign nxt_idx = idx_q + 4'd1;

  always_comb begin
    nxt_byte = HEADER;
    case (nxt_idx)
      4'd1:    nxt_byte = per_q[23:16];
      4'd2:    nxt_byte = per_q[15:8];
      4'd3:    nxt_byte = per_q[7:0];
      4'd4:    nxt_byte = p1wid_q[15:8];
      4'd5:    nxt_byte = p1wid_q[7:0];
      4'd6:    nxt_byte = del_q[15:8];
      4'd7:    nxt_byte = del_q[7:0];
      4'd8:    nxt_byte = p2wid_q[15:8];
      4'd9:    nxt_byte = p2wid_q[7:0];
      4'd10:   nxt_byte = p_bl_q;
      4'd11:   nxt_byte = flags_q;
      4'd12:   nxt_byte = csum_q;
      default: nxt_byte = HEADER;
    endcase
  end

  // LOAD and NEXT each occupy the first cycle of a byte; the next byte is
  // handed to the UART in the byte_done cycle so bytes stay gapless.
  // FINISH is the done cycle, and doubles as the accept point for a queued
  // request so the inter-frame idle is a single cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    pend_d    = pend_q;
    accept    = 1'b0;
    start_req = 1'b0;
    tx_byte   = HEADER;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      FS_IDLE: begin
        busy   = 1'b0;
        accept = send;
      end
      FS_LOAD, FS_NEXT: begin
        state_d = FS_SHIFT;
      end
      FS_SHIFT: begin
        if (byte_done) begin
          if (idx_q < LAST_BYTE) begin
            start_req = 1'b1;
            tx_byte   = nxt_byte;
            idx_d     = nxt_idx;
            if (nxt_idx != LAST_BYTE) begin
              csum_d = csum_q + nxt_byte;
            end
            state_d = FS_NEXT;
          end else begin
            state_d = FS_FINISH;
          end
        end
      end
      FS_FINISH: begin
        done   = 1'b1;
        busy   = pend_q;
        accept = pend_q || send;
        if (!accept) begin
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    if (busy && send && !pend_q && (state_q != FS_FINISH)) begin
      pend_d = 1'b1;
    end

    if (accept) begin
      start_req = 1'b1;
      tx_byte   = HEADER;
      idx_d     = '0;
      csum_d    = '0;
      pend_d    = 1'b0;
      state_d   = FS_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    csum_q <= csum_d;
    if (accept) begin
      per_q   <= per;
      p1wid_q <= p1wid;
      del_q   <= del;
      p2wid_q <= p2wid;
      p_bl_q  <= p_bl;
      flags_q <= flags_live;
    end
  end

  assign uart_start = start_req && uart_ready;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .reset    (reset),
    .start    (uart_start),
    .data     (tx_byte),
    .tx       (tx),
    .ready    (uart_ready),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_param_readback_tx.sv
module tb_param_readback_tx;

  localparam int CPB   = 4;
  localparam int CPB_B = 104;
  localparam int FRAME = 130 * CPB;

  typedef struct {
    logic [23:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  p_bl;
    logic        cp;
    logic        bl;
    logic [7:0]  flags;
    logic [7:0]  csum;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send = 1'b0;
  logic        send_b = 1'b0;
  logic [23:0] per = '0;
  logic [15:0] p1wid = '0, del = '0, p2wid = '0;
  logic [7:0]  p_bl = '0;
  logic        cp = 1'b0, bl = 1'b0;
  logic        tx, busy, done, tx_b, busy_b, done_b;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  bit          rx_abort = 1'b0;
  vec_t        vecs[4];

  param_readback_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .send(send), .per(per), .p1wid(p1wid),
    .del(del), .p2wid(p2wid), .p_bl(p_bl), .cp(cp), .bl(bl),
    .tx(tx), .busy(busy), .done(done)
  );

  param_readback_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .reset(reset), .send(send_b), .per(per), .p1wid(p1wid),
    .del(del), .p2wid(p2wid), .p_bl(p_bl), .cp(cp), .bl(bl),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_fields(input vec_t v);
    per = v.per; p1wid = v.p1wid; del = v.del; p2wid = v.p2wid;
    p_bl = v.p_bl; cp = v.cp; bl = v.bl;
  endtask

  task automatic push_frame(input vec_t v);
    exp_q.push_back(8'hA5);
    exp_q.push_back(v.per[23:16]); exp_q.push_back(v.per[15:8]); exp_q.push_back(v.per[7:0]);
    exp_q.push_back(v.p1wid[15:8]); exp_q.push_back(v.p1wid[7:0]);
    exp_q.push_back(v.del[15:8]); exp_q.push_back(v.del[7:0]);
    exp_q.push_back(v.p2wid[15:8]); exp_q.push_back(v.p2wid[7:0]);
    exp_q.push_back(v.p_bl);
    exp_q.push_back(v.flags);
    exp_q.push_back(v.csum);
  endtask

  // UART receiver model on the CPB=4 instance: samples mid-bit on negedges
  initial begin
    logic [7:0] rb;
    logic       stopb;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !reset) begin
        rx_abort = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          rb[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        stopb = tx;
        if (!rx_abort) begin
          check("rx_stop_bit", stopb, 1);
          if (exp_q.size() == 0) check("rx_extra_byte", exp_q.size(), 1);
          else check("rx_byte", rb, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_frame(input vec_t v, input bit mutate);
    int t0;
    bit got;
    @(negedge clk);
    apply_fields(v);
    push_frame(v);
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    t0 = cyc;
    check("tx_start_after_send", tx, 0);
    check("busy_after_send", busy, 1);
    got = 1'b0;
    for (int i = 0; i < FRAME + 100 && !got; i++) begin
      @(negedge clk);
      if (mutate && cyc == t0 + 90) begin
        per = 24'hFFFFFF; p_bl = 8'h00; cp = 1'b0; bl = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        check("done_latency", cyc - t0, FRAME);
        check("busy_at_done", busy, 0);
        check("tx_at_done", tx, 1);
        check("queue_empty_at_done", exp_q.size(), 0);
        @(negedge clk);
        check("done_width", done, 0);
      end
    end
    check("done_seen", got, 1);
  endtask

  initial begin
    vec_t v2;
    int   t0, nd, d1, d2, bad_busy, nb, edge_err, nedges, dcount;
    logic gap_tx, prev;
    bit   fin;

    vecs[0] = '{per:24'h0186A0, p1wid:16'h0032, del:16'h00C8, p2wid:16'h0064,
                p_bl:8'h03, cp:1'b1, bl:1'b0, flags:8'h01, csum:8'h89};
    vecs[1] = '{per:24'hFFFFFF, p1wid:16'hFFFF, del:16'hFFFF, p2wid:16'hFFFF,
                p_bl:8'hFF, cp:1'b1, bl:1'b1, flags:8'h03, csum:8'hF9};
    vecs[2] = '{per:24'h123456, p1wid:16'hABCD, del:16'h0001, p2wid:16'hFFFE,
                p_bl:8'h80, cp:1'b0, bl:1'b1, flags:8'h02, csum:8'h94};
    vecs[3] = '{per:24'h000000, p1wid:16'h0000, del:16'h0000, p2wid:16'h0000,
                p_bl:8'h00, cp:1'b0, bl:1'b0, flags:8'h00, csum:8'h00};

    // Reset state, and a send coincident with reset is ignored
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_tx_b", tx_b, 1);
    @(negedge clk);
    send = 1'b1;
    @(posedge clk); #1;
    check("send_in_reset_busy", busy, 0);
    check("send_in_reset_tx", tx, 1);
    @(negedge clk);
    send = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // Table of frames
    for (int i = 0; i < 4; i++) do_frame(vecs[i], 1'b0);

    // Snapshot isolation: inputs change during byte 2
    do_frame(vecs[0], 1'b1);

    // Pending request, plus a third send that must be dropped
    v2 = vecs[0];
    v2.cp = 1'b0; v2.bl = 1'b1; v2.flags = 8'h02; v2.csum = 8'h8A;
    @(negedge clk);
    apply_fields(vecs[0]);
    push_frame(vecs[0]);
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    t0 = cyc;
    nd = 0; d1 = 0; d2 = 0; bad_busy = 0; gap_tx = 1'b1;
    for (int i = 0; i < 3 * FRAME + 100; i++) begin
      @(negedge clk);
      if (cyc == t0 + 100) begin
        cp = 1'b0; bl = 1'b1; send = 1'b1;
        push_frame(v2);
      end else if (cyc == t0 + 300) begin
        send = 1'b1;
      end else begin
        send = 1'b0;
      end
      if (nd == 1 && cyc == d1 + 1) gap_tx = tx;
      if (done) begin
        if (nd == 0) begin
          d1 = cyc;
          check("pend_busy_at_done1", busy, 1);
          check("pend_tx_at_done1", tx, 1);
        end else if (nd == 1) begin
          d2 = cyc;
        end
        nd++;
      end else if (nd < 2 && !busy) begin
        bad_busy++;
      end
    end
    check("pend_done_count", nd, 2);
    check("pend_frame1_latency", d1 - t0, FRAME);
    check("pend_frame_spacing", d2 - d1, FRAME + 1);
    check("pend_start_after_gap", gap_tx, 0);
    check("pend_busy_drops", bad_busy, 0);
    check("pend_queue_empty", exp_q.size(), 0);

    // Reset mid-frame at byte 5, bit 3
    @(negedge clk);
    apply_fields(vecs[0]);
    push_frame(vecs[0]);
    send = 1'b1;
    @(posedge clk); #1;
    send = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 5 * 10 * CPB + 3 * CPB; i++) @(negedge clk);
    reset = 1'b1;
    rx_abort = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < FRAME + 80; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy) dcount++;
    end
    check("midreset_no_done_or_busy", dcount, 0);
    do_frame(vecs[0], 1'b0);

    // Baud timing on the CLKS_PER_BIT=104 instance
    @(negedge clk);
    apply_fields(vecs[0]);
    send_b = 1'b1;
    @(posedge clk); #1;
    send_b = 1'b0;
    t0 = cyc;
    prev = 1'b1; nb = 0; edge_err = 0; nedges = 0; fin = 1'b0;
    for (int i = 0; i < 130 * CPB_B + 200 && !fin; i++) begin
      @(negedge clk);
      if (tx_b !== prev) begin
        nedges++;
        if ((cyc - t0) % CPB_B != 0) edge_err++;
        prev = tx_b;
      end
      if (busy_b) nb++;
      else begin
        fin = 1'b1;
        check("baud_done_at_end", done_b, 1);
      end
    end
    check("baud_frame_ended", fin, 1);
    check("baud_busy_cycles", nb, 130 * CPB_B);
    check("baud_edge_alignment", edge_err, 0);
    check("baud_has_edges", nedges > 20, 1);

    repeat (20) @(negedge clk);
    check("final_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
